// File: rtl/mips_cpu_mem_arbiter_pkg.sv
// Shared definitions for the MIPS CPU memory arbiter: FSM state encoding,
// the full byte-lane mask and the word-alignment helper.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } arb_state_e;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_BUSY_I = BUSY_I;
    localparam logic [1:0] ST_BUSY_D = BUSY_D;

    localparam logic [3:0] BE_ALL = 4'b1111;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_cpu_mem_arbiter_if.sv
// Bundle of the instruction port, data port and unified memory bus seen by
// the arbiter (master) and by its surroundings (slave).
interface mips_cpu_mem_arbiter_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;

    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteen;
    logic        d_ack;
    logic [31:0] d_rdata;

    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_waitrequest;
    logic [31:0] m_readdata;

    modport master (
        input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_byteen,
               m_waitrequest, m_readdata,
        output i_ack, i_rdata, d_ack, d_rdata,
               m_address, m_read, m_write, m_writedata, m_byteenable
    );

    modport slave (
        output i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_byteen,
               m_waitrequest, m_readdata,
        input  i_ack, i_rdata, d_ack, d_rdata,
               m_address, m_read, m_write, m_writedata, m_byteenable
    );

endinterface

// File: rtl/mips_cpu_mem_arbiter.sv
// Arbitrates instruction fetches and data accesses onto one memory master
// port; data has priority unless the fetch side has been starved too long.
module mips_cpu_mem_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    mips_cpu_mem_arbiter_if.master        bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [1:0]       state_r;
    logic [CNT_W-1:0] starve_cnt_r;
    logic             i_ack_r;
    logic             d_ack_r;
    logic [31:0]      i_rdata_r;
    logic [31:0]      d_rdata_r;
    logic [31:0]      m_address_r;
    logic             m_read_r;
    logic             m_write_r;
    logic [31:0]      m_writedata_r;
    logic [3:0]       m_byteenable_r;

    logic             d_req_s;
    logic             i_pend_s;
    logic             d_wins_s;
    logic             grant_d_s;
    logic             grant_i_s;
    logic             d_null_s;

    // An acked requester cannot be re-granted in its ack cycle, but a still
    // asserted data request keeps its priority so it is not overtaken early.
    always_comb begin
        d_req_s   = bus.d_read | bus.d_write;
        i_pend_s  = bus.i_req & ~i_ack_r;
        d_wins_s  = 1'b0;
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        d_null_s  = 1'b0;
        if (d_req_s && !(i_pend_s && (starve_cnt_r == CNT_MAX))) begin
            d_wins_s = 1'b1;
        end else begin
            d_wins_s = 1'b0;
        end
        if (state_r == ST_IDLE) begin
            grant_d_s = d_wins_s & ~d_ack_r;
            grant_i_s = i_pend_s & ~d_wins_s;
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
        d_null_s = grant_d_s & bus.d_write & (bus.d_byteen == 4'b0000);
    end

    // FSM, registered bus command, starvation counter, acks and read data
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            starve_cnt_r   <= '0;
            i_ack_r        <= 1'b0;
            d_ack_r        <= 1'b0;
            i_rdata_r      <= 32'h0000_0000;
            d_rdata_r      <= 32'h0000_0000;
            m_address_r    <= 32'h0000_0000;
            m_read_r       <= 1'b0;
            m_write_r      <= 1'b0;
            m_writedata_r  <= 32'h0000_0000;
            m_byteenable_r <= 4'b0000;
        end else begin
            i_ack_r <= 1'b0;
            d_ack_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_d_s) begin
                        if (i_pend_s && (starve_cnt_r != CNT_MAX)) begin
                            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
                        end
                        if (d_null_s) begin
                            d_ack_r <= 1'b1;
                        end else begin
                            state_r        <= ST_BUSY_D;
                            m_address_r    <= word_align(bus.d_addr);
                            m_read_r       <= ~bus.d_write;
                            m_write_r      <= bus.d_write;
                            m_writedata_r  <= bus.d_wdata;
                            m_byteenable_r <= bus.d_write ? bus.d_byteen : BE_ALL;
                        end
                    end else if (grant_i_s) begin
                        starve_cnt_r   <= '0;
                        state_r        <= ST_BUSY_I;
                        m_address_r    <= word_align(bus.i_addr);
                        m_read_r       <= 1'b1;
                        m_write_r      <= 1'b0;
                        m_byteenable_r <= BE_ALL;
                    end
                end
                ST_BUSY_I: begin
                    if (!bus.m_waitrequest) begin
                        i_rdata_r <= bus.m_readdata;
                        i_ack_r   <= 1'b1;
                        m_read_r  <= 1'b0;
                        m_write_r <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_BUSY_D: begin
                    if (!bus.m_waitrequest) begin
                        d_rdata_r <= bus.m_readdata;
                        d_ack_r   <= 1'b1;
                        m_read_r  <= 1'b0;
                        m_write_r <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    m_read_r  <= 1'b0;
                    m_write_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.i_ack        = i_ack_r;
    assign bus.i_rdata      = i_rdata_r;
    assign bus.d_ack        = d_ack_r;
    assign bus.d_rdata      = d_rdata_r;
    assign bus.m_address    = m_address_r;
    assign bus.m_read       = m_read_r;
    assign bus.m_write      = m_write_r;
    assign bus.m_writedata  = m_writedata_r;
    assign bus.m_byteenable = m_byteenable_r;

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Directed bench for mips_cpu_mem_arbiter: inputs change 1 time unit after
// each rising edge and outputs are checked at that same point.
module tb_mips_cpu_mem_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   n_dack;
    logic got_iack;

    mips_cpu_mem_arbiter_if bus();

    mips_cpu_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.i_req = 1'b0;          bus.i_addr = 32'h0000_0000;
        bus.d_read = 1'b0;         bus.d_write = 1'b0;
        bus.d_addr = 32'h0000_0000; bus.d_wdata = 32'h0000_0000;
        bus.d_byteen = 4'b0000;
        bus.m_waitrequest = 1'b0;  bus.m_readdata = 32'h0000_0000;

        // reset state
        tick(); tick();
        chk("rst_ctrl", {28'h0, bus.i_ack, bus.d_ack, bus.m_read, bus.m_write}, 32'h0);
        chk("rst_addr", bus.m_address, 32'h0);
        chk("rst_wdata", bus.m_writedata, 32'h0);
        chk("rst_be", {28'h0, bus.m_byteenable}, 32'h0);
        chk("rst_irdata", bus.i_rdata, 32'h0);
        chk("rst_drdata", bus.d_rdata, 32'h0);
        chk("rst_cnt", 32'(dut.starve_cnt_r), 32'h0);
        reset = 1'b0;
        tick();

        // single fetch
        bus.i_req = 1'b1; bus.i_addr = 32'hBFC0_0002; bus.m_readdata = 32'h1234_5678;
        tick();
        chk("fetch_mread", {31'h0, bus.m_read}, 32'h1);
        chk("fetch_addr", bus.m_address, 32'hBFC0_0000);
        chk("fetch_be", {28'h0, bus.m_byteenable}, 32'hF);
        chk("fetch_noack", {31'h0, bus.i_ack}, 32'h0);
        tick();
        chk("fetch_iack", {31'h0, bus.i_ack}, 32'h1);
        chk("fetch_rdata", bus.i_rdata, 32'h1234_5678);
        chk("fetch_mdrop", {31'h0, bus.m_read}, 32'h0);
        bus.i_req = 1'b0;
        tick();
        chk("fetch_idle", {30'h0, bus.i_ack, bus.m_read}, 32'h0);

        // collision: data first, fetch granted in the d_ack cycle
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0040;
        bus.d_read = 1'b1; bus.d_addr = 32'h0000_0207; bus.m_readdata = 32'hAAAA_0001;
        tick();
        chk("col_d_addr", bus.m_address, 32'h0000_0204);
        chk("col_d_rd", {30'h0, bus.m_read, bus.m_write}, 32'h2);
        tick();
        chk("col_dack", {30'h0, bus.d_ack, bus.i_ack}, 32'h2);
        chk("col_drdata", bus.d_rdata, 32'hAAAA_0001);
        bus.d_read = 1'b0; bus.m_readdata = 32'hBBBB_0002;
        tick();
        chk("col_i_addr", bus.m_address, 32'h0000_0040);
        chk("col_i_rd", {30'h0, bus.m_read, bus.d_ack}, 32'h2);
        tick();
        chk("col_iack", {31'h0, bus.i_ack}, 32'h1);
        chk("col_irdata", bus.i_rdata, 32'hBBBB_0002);
        chk("col_drdata_hold", bus.d_rdata, 32'hAAAA_0001);
        bus.i_req = 1'b0;
        tick();
        chk("col_cnt", 32'(dut.starve_cnt_r), 32'h0);

        // starvation: fetch held while data keeps requesting
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0080;
        bus.d_read = 1'b1; bus.d_addr = 32'h0000_0300; bus.m_readdata = 32'hCAFE_0000;
        n_dack = 0; got_iack = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("starve_excl_ack", {31'h0, bus.i_ack & bus.d_ack}, 32'h0);
            chk("starve_excl_rw", {31'h0, bus.m_read & bus.m_write}, 32'h0);
            if (bus.d_ack) n_dack++;
            if (bus.i_ack) begin
                got_iack = 1'b1;
                break;
            end
        end
        chk("starve_iack_seen", {31'h0, got_iack}, 32'h1);
        chk("starve_dacks", 32'(n_dack), 32'd4);
        bus.i_req = 1'b0; bus.d_read = 1'b0;
        tick();
        chk("starve_cnt", 32'(dut.starve_cnt_r), 32'h0);
        chk("starve_idle", {30'h0, bus.m_read, bus.m_write}, 32'h0);

        // wait states on a partial write
        bus.d_write = 1'b1; bus.d_addr = 32'h0000_0100; bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_byteen = 4'b0011; bus.m_waitrequest = 1'b1; bus.m_readdata = 32'h0000_0055;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.m_waitrequest = 1'b0;
            chk("ws_addr", bus.m_address, 32'h0000_0100);
            chk("ws_wdata", bus.m_writedata, 32'hDEAD_BEEF);
            chk("ws_ctl", {26'h0, bus.m_byteenable, bus.m_write, bus.m_read}, 32'h0000_000E);
            chk("ws_noack", {31'h0, bus.d_ack}, 32'h0);
            if (k < 3) tick();
        end
        tick();
        chk("ws_dack", {31'h0, bus.d_ack}, 32'h1);
        chk("ws_wdrop", {31'h0, bus.m_write}, 32'h0);
        chk("ws_drdata", bus.d_rdata, 32'h0000_0055);
        bus.d_write = 1'b0;
        tick();

        // zero byte-enable write completes without a bus command
        bus.d_write = 1'b1; bus.d_addr = 32'h0000_0200; bus.d_byteen = 4'b0000;
        tick();
        chk("zbe_dack", {29'h0, bus.d_ack, bus.m_write, bus.m_read}, 32'h4);
        bus.d_write = 1'b0;
        tick();
        chk("zbe_after", {29'h0, bus.d_ack, bus.m_write, bus.m_read}, 32'h0);

        // reset aborts a stalled data read, even with waitrequest falling
        bus.d_read = 1'b1; bus.d_addr = 32'h0000_0010; bus.m_waitrequest = 1'b1;
        tick();
        chk("rab_mread", {31'h0, bus.m_read}, 32'h1);
        tick();
        reset = 1'b1; bus.m_waitrequest = 1'b0; bus.d_read = 1'b0;
        tick();
        chk("rab_ctl", {29'h0, bus.m_read, bus.m_write, bus.d_ack}, 32'h0);
        chk("rab_drdata", bus.d_rdata, 32'h0);
        reset = 1'b0;
        tick();
        chk("rab_noack", {30'h0, bus.d_ack, bus.i_ack}, 32'h0);
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_1004; bus.m_readdata = 32'h0000_600D;
        tick();
        chk("rab_i_addr", bus.m_address, 32'h0000_1004);
        chk("rab_i_rd", {31'h0, bus.m_read}, 32'h1);
        tick();
        chk("rab_iack", {31'h0, bus.i_ack}, 32'h1);
        chk("rab_irdata", bus.i_rdata, 32'h0000_600D);
        bus.i_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
